// File: rtl/y_bcd_reader.sv
// Reads register Y's output bus and converts it into five packed BCD digits,
// one double-dabble iteration per clock, behind a START/BUSY/DONE handshake.
module y_bcd_reader #(
    parameter int SIGNED = 0,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [19:0]      bcd,
    output logic             neg
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   mag_reg;
    logic [19:0]        scratch_reg;
    logic               sgn_reg;
    logic [4:0]         cnt_reg;

    logic               in_neg;
    logic [WIDTH-1:0]   in_mag;
    logic [19:0]        adj;
    logic [WIDTH+19:0]  shifted;

    // 0x8000 negates to itself, which is exactly the unsigned magnitude 32768
    assign in_neg = (SIGNED != 0) && in[WIDTH-1];
    assign in_mag = in_neg ? -in : in;

    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                              ? scratch_reg[4*gi +: 4] + 4'd3
                              : scratch_reg[4*gi +: 4];
    end

    assign shifted = {adj, mag_reg} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mag_reg     <= '0;
            scratch_reg <= '0;
            sgn_reg     <= 1'b0;
            cnt_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            neg         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mag_reg     <= in_mag;
                        sgn_reg     <= in_neg;
                        scratch_reg <= '0;
                        cnt_reg     <= '0;
                        busy        <= 1'b1;
                        state_reg   <= CONV;
                    end
                end
                CONV: begin
                    scratch_reg <= shifted[WIDTH+19:WIDTH];
                    mag_reg     <= shifted[WIDTH-1:0];
                    cnt_reg     <= cnt_reg + 5'd1;
                    // Sixteenth shift: publish the result in the same edge
                    if (cnt_reg == 5'd15) begin
                        bcd       <= shifted[WIDTH+19:WIDTH];
                        neg       <= sgn_reg;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y_bcd_reader.sv
// Randomised and directed checks of y_bcd_reader (unsigned and signed builds
// side by side) against a decimal-digit reference model.
module tb_y_bcd_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic        busy_u, done_u, neg_u, busy_s, done_s, neg_s;
    logic [19:0] bcd_u, bcd_s;

    int          vectors = 0;
    int          errors  = 0;
    logic [19:0] last_u, last_s;
    logic        last_neg_s;
    int          lat;

    always #5 clk = ~clk;

    y_bcd_reader #(.SIGNED(0), .WIDTH(16)) u_uns (
        .clk(clk), .rst(rst), .start(start), .in(din),
        .busy(busy_u), .done(done_u), .bcd(bcd_u), .neg(neg_u)
    );

    y_bcd_reader #(.SIGNED(1), .WIDTH(16)) u_sgn (
        .clk(clk), .rst(rst), .start(start), .in(din),
        .busy(busy_s), .done(done_s), .bcd(bcd_s), .neg(neg_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned mag_of(input logic [15:0] v, input bit signed_mode);
        int unsigned x;
        x = v;
        if (signed_mode && x >= 32768) return 65536 - x;
        return x;
    endfunction

    // Waits from just after the accepting edge until DONE is seen at a negedge.
    task automatic wait_done(input string tag, input bit scramble, input int inject_at,
                             input logic [15:0] inject_val, output int lat_o);
        bit got;
        got   = 1'b0;
        lat_o = 0;
        while (!got && lat_o < 40) begin
            @(negedge clk);
            if (done_u) begin
                got = 1'b1;
            end else begin
                check({tag, "_busy_u"}, busy_u, 1'b1);
                check({tag, "_busy_s"}, busy_s, 1'b1);
                if (lat_o == 8) begin
                    check({tag, "_hold_u"}, bcd_u, last_u);
                    check({tag, "_hold_s"}, bcd_s, last_s);
                    check({tag, "_hold_neg"}, neg_s, last_neg_s);
                end
                if (scramble) din = 16'($urandom);
                start = (lat_o == inject_at);
                if (lat_o == inject_at) din = inject_val;
                @(posedge clk);
                lat_o++;
                #1 start = 1'b0;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic finish_checks(input string tag, input logic [15:0] v, input int lat_i);
        logic [19:0] eu, es;
        logic        en;
        eu = to_bcd(mag_of(v, 1'b0));
        es = to_bcd(mag_of(v, 1'b1));
        en = v[15];
        check({tag, "_lat"},    lat_i, 32'd16);
        check({tag, "_bcd_u"},  bcd_u, eu);
        check({tag, "_bcd_s"},  bcd_s, es);
        check({tag, "_neg_u"},  neg_u, 1'b0);
        check({tag, "_neg_s"},  neg_s, en);
        check({tag, "_excl_u"}, busy_u, 1'b0);
        check({tag, "_done_s"}, done_s, 1'b1);
        last_u     = eu;
        last_s     = es;
        last_neg_s = en;
        $display("%s in=%h bcd_u=%h bcd_s=%h neg_s=%b lat=%0d", tag, v, bcd_u, bcd_s, neg_s, lat_i);
    endtask

    task automatic run_conv(input string tag, input logic [15:0] v, input bit scramble);
        int l;
        @(negedge clk);
        din   = v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag, scramble, -1, 16'h0, l);
        finish_checks(tag, v, l);
        @(negedge clk);
        check({tag, "_pulse"}, done_u, 1'b0);
        check({tag, "_idle"},  busy_u, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_bcd_u"},  bcd_u,  20'h0);
        check({tag, "_bcd_s"},  bcd_s,  20'h0);
        check({tag, "_neg_s"},  neg_s,  1'b0);
        check({tag, "_busy_u"}, busy_u, 1'b0);
        check({tag, "_busy_s"}, busy_s, 1'b0);
        check({tag, "_done_u"}, done_u, 1'b0);
        last_u     = '0;
        last_s     = '0;
        last_neg_s = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        run_conv("max_ffff", 16'hFFFF, 1'b1);
        check("max_ffff_lit", bcd_u, 20'h65535);
        run_conv("pattern", 16'b1011110010100010, 1'b1);
        check("pattern_lit", bcd_u, 20'h48290);
        run_conv("zero", 16'h0000, 1'b0);
        run_conv("s_8000", 16'h8000, 1'b1);
        check("s_8000_lit", bcd_s, 20'h32768);
        run_conv("s_7fff", 16'h7FFF, 1'b0);
        check("s_7fff_lit", bcd_s, 20'h32767);

        // Asynchronous reset in idle, observed before any clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_cleared("idle_rst");
        @(negedge clk);
        rst = 1'b0;

        // Request while busy is ignored; request in the DONE cycle is taken
        @(negedge clk);
        din   = 16'd1234;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy_ign", 1'b0, 5, 16'd9999, lat);
        finish_checks("busy_ign", 16'd1234, lat);
        check("busy_ign_lit", bcd_u, 20'h01234);
        din   = 16'd42;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("done_cyc", 1'b0, -1, 16'h0, lat);
        finish_checks("done_cyc", 16'd42, lat);
        check("done_cyc_lit", bcd_u, 20'h00042);

        // Reset mid-conversion discards the partial result
        run_conv("pre_rst", 16'd500, 1'b0);
        @(negedge clk);
        din   = 16'd777;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_cleared("conv_rst");
        @(negedge clk);
        rst = 1'b0;
        run_conv("post_rst", 16'd10, 1'b0);
        check("post_rst_lit", bcd_u, 20'h00010);

        for (int i = 0; i < 30; i++) begin
            run_conv($sformatf("rand%0d", i), 16'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
